mod997_crt_reconstruct: RTL

- Sequential residue-to-binary converter: the inverse of the binary-to-residue mod-997 LUT reducers.
- Takes a residue pair (r1 = X mod 997, r2 = X mod 1024) and reconstructs X, 0 <= X < 1020928, by two-step mixed-radix CRT:
  - t = ((r2 - r1) * 493) mod 1024
  - X = r1 + 997*t
- Both multiplies are bit-serial shift-add, so the block is small.
- Sits at the output of the residue datapath and hands binary results back to the host side over a valid/ready interface.

---
 rtl/mod997_crt_reconstruct.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mod997_crt_reconstruct.sv
// mod997_crt_reconstruct
//
// Residue-to-binary converter for the pair (r1 = X mod M1, r2 = X mod 2^W).
// It rebuilds X with a two-step mixed-radix CRT:
//   t = ((r2 - r1) * INV) mod 2^W
//   X = r1 + M1 * t
// Both multiplies are bit-serial shift-add, one multiplier bit per cycle.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   residue pair valid
//   in_ready   block can accept a pair (IDLE only)
//   in_r1      X mod M1, legal range 0..M1-1
//   in_r2      X mod 2^W, any value legal
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_x      reconstructed X (0 when out_err)
//   out_err    in_r1 was >= M1
//   busy       FSM is in any state other than IDLE
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. valid never drops and data never changes while waiting for ready.
// ready does not depend on valid. Only one pair is in flight at a time.
module mod997_crt_reconstruct #(
  parameter int M1  = 997,
  parameter int W   = 10,
  parameter int INV = 493,
  parameter int XW  = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_r1,
  input  logic [W-1:0]  in_r2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW-1:0] out_x,
  output logic          out_err,
  output logic          busy
);

  localparam int CW = $clog2(W);
  localparam logic [W-1:0]  M1_W  = W'(M1);
  localparam logic [XW-1:0] M1_X  = XW'(M1);
  localparam logic [W-1:0]  INV_W = W'(INV);
  localparam logic [CW-1:0] LAST  = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_INV = 2'd1,
    MUL_M   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    d_q, d_d;       // (r2 - r1) mod 2^W
  logic [W-1:0]    acc_q, acc_d;   // becomes t after MUL_INV
  logic [XW-1:0]   xacc_q, xacc_d; // starts at r1, ends at r1 + M1*t
  logic [CW-1:0]   cnt_q, cnt_d;   // multiplier bit index
  logic            err_q, err_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    acc_d       = acc_q;
    xacc_d      = xacc_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          d_d   = in_r2 - in_r1;   // W-bit wraparound gives the mod 2^W difference
          acc_d = '0;
          cnt_d = '0;
          if (in_r1 >= M1_W) begin
            err_d   = 1'b1;
            xacc_d  = '0;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            xacc_d  = {{(XW-W){1'b0}}, in_r1};  // r1 is the constant term of X
            state_d = MUL_INV;
          end
        end
      end

      MUL_INV: begin
        // Only the low W bits of the product are needed, so acc wraps freely.
        if (INV_W[cnt_q]) acc_d = acc_q + (d_q << cnt_q);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = MUL_M;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      MUL_M: begin
        if (acc_q[cnt_q]) xacc_d = xacc_q + (M1_X << cnt_q);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        // out_valid rises one edge after DONE is entered and drops on the
        // same edge that returns the FSM to IDLE.
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      d_q         <= '0;
      acc_q       <= '0;
      xacc_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      acc_q       <= acc_d;
      xacc_q      <= xacc_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_x     = xacc_q;
  assign out_err   = err_q;
  assign busy      = busy_q;

endmodule
